// File: rtl/defs_pkg.sv
// Shared definitions for the sequential ALU.
//   alu_ext_op_t : 4-bit operation code (base ops 0..7, MULU=8, DIVU=9, 10..15 illegal)
//   alu_flags_t  : result flags {carry, overflow, zero, negative}
//   alu_state_t  : control FSM states of alu_seq
// Related build option: ALU_MULDIV_EN enables the iterative MULU/DIVU datapath.
package defs_pkg;

  localparam int ALU_EXT_OP_W = 4;

  typedef enum logic [ALU_EXT_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_MULU = 4'd8,
    ALU_DIVU = 4'd9
  } alu_ext_op_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } alu_flags_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one step per cycle.
// Only built when ALU_MULDIV_EN is defined.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start_i          : load operands and begin WIDTH steps
//   is_div_i         : 1 = divide, 0 = multiply (sampled on start_i)
//   a_i, b_i         : operands (sampled on start_i)
//   busy_o           : steps remaining
//   done_o           : the current cycle performs the final step
//   hi_o, lo_o       : value the partial registers take this cycle;
//                      final {hi,lo} of MUL or {remainder,quotient} of DIV when done_o
//   is_div_o, dbz_o  : running op is a divide / divide by zero
module alu_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             is_div_o,
  output logic             dbz_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic             is_div_q;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_trial_s;
  logic [WIDTH-1:0] hi_nx_s, lo_nx_s;

  // One multiply or divide step computed from the partial registers.
  // MUL: hi accumulates b when the multiplier LSB (lo[0]) is set, then {hi,lo} shifts right.
  // DIV: lo holds the dividend being shifted out and the quotient shifted in; hi is the
  //      partial remainder. With b = 0 every trial succeeds, giving all-ones / remainder = a.
  always_comb begin
    mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_trial_s = {hi_q, lo_q[WIDTH-1]} - {1'b0, b_q};
    if (!is_div_q) begin
      hi_nx_s = mul_sum_s[WIDTH:1];
      lo_nx_s = {mul_sum_s[0], lo_q[WIDTH-1:1]};
    end else if (!div_trial_s[WIDTH]) begin
      hi_nx_s = div_trial_s[WIDTH-1:0];
      lo_nx_s = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_nx_s = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      lo_nx_s = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Operand latch, step counter and partial registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
    end else if (start_i) begin
      cnt_q    <= CNT_W'(WIDTH);
      hi_q     <= '0;
      lo_q     <= a_i;
      b_q      <= b_i;
      is_div_q <= is_div_i;
    end else if (cnt_q != '0) begin
      cnt_q    <= cnt_q - CNT_W'(1);
      hi_q     <= hi_nx_s;
      lo_q     <= lo_nx_s;
    end else begin
      cnt_q    <= cnt_q;
    end
  end

  assign busy_o   = (cnt_q != '0);
  assign done_o   = (cnt_q == CNT_W'(1));
  assign hi_o     = hi_nx_s;
  assign lo_o     = lo_nx_s;
  assign is_div_o = is_div_q;
  assign dbz_o    = is_div_q && (b_q == '0);

endmodule

// File: rtl/alu_seq.sv
// Sequential handshaked ALU: base ops in one cycle, optional iterative MULU/DIVU.
// Build option: ALU_MULDIV_EN (defined = MULU/DIVU iterative over WIDTH cycles;
// undefined = MULU/DIVU behave as illegal ops, busy tied 0).
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : issue handshake; in1, in2 operands, op operation code
//   out_valid/out_ready   : writeback handshake
//   out, out_hi, flags    : registered result (low / high half, remainder) and flags
//   busy                  : iterative op in progress
import defs_pkg::*;

module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  alu_ext_op_t      op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output alu_flags_t       flags,
  output logic             busy
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic               accept_s, load_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH-1:0]   base_lo_s;
  logic               base_carry_s, base_ovf_s;
  logic [WIDTH-1:0]   res_lo_s, res_hi_s;
  logic               res_carry_s, res_ovf_s;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_q, out_d, out_hi_q, out_hi_d;
  alu_flags_t         flags_q, flags_d;

  assign accept_s = in_valid && in_ready;
  assign shamt_s  = in2[SHAMT_W-1:0];

  // Single-cycle base operations; anything not listed (including MULU/DIVU when
  // the iterative unit is absent) is illegal: zero result with overflow set.
  always_comb begin
    sum_s        = '0;
    base_lo_s    = '0;
    base_carry_s = 1'b0;
    base_ovf_s   = 1'b0;
    case (op)
      ALU_ADD: begin
        sum_s        = {1'b0, in1} + {1'b0, in2};
        base_lo_s    = sum_s[WIDTH-1:0];
        base_carry_s = sum_s[WIDTH];
        base_ovf_s   = (in1[WIDTH-1] == in2[WIDTH-1]) && (base_lo_s[WIDTH-1] != in1[WIDTH-1]);
      end
      ALU_SUB: begin
        sum_s        = {1'b0, in1} - {1'b0, in2};
        base_lo_s    = sum_s[WIDTH-1:0];
        base_carry_s = sum_s[WIDTH];  // borrow out
        base_ovf_s   = (in1[WIDTH-1] != in2[WIDTH-1]) && (base_lo_s[WIDTH-1] != in1[WIDTH-1]);
      end
      ALU_AND: base_lo_s = in1 & in2;
      ALU_OR:  base_lo_s = in1 | in2;
      ALU_XOR: base_lo_s = in1 ^ in2;
      ALU_SLL: base_lo_s = in1 << shamt_s;
      ALU_SRL: base_lo_s = in1 >> shamt_s;
      ALU_SRA: base_lo_s = $signed(in1) >>> shamt_s;
      default: base_ovf_s = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  alu_state_t       state_q, state_d;
  logic             is_md_s, md_start_s, md_busy_s, md_done_s, md_is_div_s, md_dbz_s;
  logic [WIDTH-1:0] md_hi_s, md_lo_s;

  assign is_md_s    = (op == ALU_MULU) || (op == ALU_DIVU);
  assign md_start_s = accept_s && is_md_s;

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (md_start_s),
    .is_div_i (op == ALU_DIVU),
    .a_i      (in1),
    .b_i      (in2),
    .busy_o   (md_busy_s),
    .done_o   (md_done_s),
    .hi_o     (md_hi_s),
    .lo_o     (md_lo_s),
    .is_div_o (md_is_div_s),
    .dbz_o    (md_dbz_s)
  );

  // Control FSM next state: IDLE accepts ops, EXEC waits for the last iterative step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (md_start_s) state_d = ST_EXEC;
        else            state_d = ST_IDLE;
      end
      ST_EXEC: begin
        if (md_done_s || !md_busy_s) state_d = ST_IDLE;
        else                         state_d = ST_EXEC;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign busy     = (state_q == ST_EXEC);
  assign load_s   = (accept_s && !is_md_s) || (md_done_s && (state_q == ST_EXEC));

  // Result source: the iterative unit's final step, otherwise the base path.
  always_comb begin
    res_lo_s    = base_lo_s;
    res_hi_s    = '0;
    res_carry_s = base_carry_s;
    res_ovf_s   = base_ovf_s;
    if (md_done_s && (state_q == ST_EXEC)) begin
      res_lo_s = md_lo_s;
      res_hi_s = md_hi_s;
      if (md_is_div_s) begin
        res_carry_s = 1'b0;
        res_ovf_s   = md_dbz_s;
      end else begin
        res_carry_s = (md_hi_s != '0);
        res_ovf_s   = (md_hi_s != '0);
      end
    end else begin
      res_hi_s = '0;
    end
  end
`else
  assign in_ready    = !out_valid_q || out_ready;
  assign busy        = 1'b0;
  assign load_s      = accept_s;
  assign res_lo_s    = base_lo_s;
  assign res_hi_s    = '0;
  assign res_carry_s = base_carry_s;
  assign res_ovf_s   = base_ovf_s;
`endif

  // Output register next state: load a new result, drop valid on transfer, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_hi_d    = out_hi_q;
    flags_d     = flags_q;
    if (load_s) begin
      out_valid_d = 1'b1;
      out_d       = res_lo_s;
      out_hi_d    = res_hi_s;
      flags_d     = '{carry:    res_carry_s,
                      overflow: res_ovf_s,
                      zero:     (res_lo_s == '0),
                      negative: res_lo_s[WIDTH-1]};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_hi_q    <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_hi_q    <= out_hi_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_hi    = out_hi_q;
  assign flags     = flags_q;

endmodule
